// File: rtl/serial_subtractor.sv
// Bit-serial a - b, one bit per clock LSB first, with a registered borrow.
// Operands arrive on a valid/ready request channel; results leave on a valid/ready response channel.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf,
  output logic             busy
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-2:0] r_sr;
  logic [CW-1:0]    cnt;
  logic             borrow;
  logic             a_msb;
  logic             b_msb;

  logic             d;
  logic             br_next;
  logic [WIDTH-1:0] r_next;

  function automatic logic [1:0] full_sub(input logic x, input logic y, input logic br);
    full_sub = {(~x & y) | (~(x ^ y) & br), x ^ y ^ br};
  endfunction

  always_comb begin
    {br_next, d} = full_sub(a_sr[0], b_sr[0], borrow);
    // New bit enters at the MSB; after WIDTH shifts bit 0 of the result sits at the LSB.
    r_next       = {d, r_sr};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      start_ready <= 1'b1;
      res_valid   <= 1'b0;
      busy        <= 1'b0;
      diff        <= '0;
      bout        <= 1'b0;
      ovf         <= 1'b0;
      a_sr        <= '0;
      b_sr        <= '0;
      r_sr        <= '0;
      cnt         <= '0;
      borrow      <= 1'b0;
      a_msb       <= 1'b0;
      b_msb       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_valid) begin
            a_sr        <= a;
            b_sr        <= b;
            a_msb       <= a[WIDTH-1];
            b_msb       <= b[WIDTH-1];
            borrow      <= 1'b0;
            cnt         <= '0;
            start_ready <= 1'b0;
            busy        <= 1'b1;
            state       <= CALC;
          end
        end
        CALC: begin
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          r_sr   <= r_next[WIDTH-1:1];
          borrow <= br_next;
          cnt    <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1)) begin
            // Output registers only change here, so they hold across IDLE until the next result.
            diff      <= r_next;
            bout      <= br_next;
            ovf       <= (a_msb != b_msb) && (d != a_msb);
            res_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (res_ready) begin
            res_valid   <= 1'b0;
            busy        <= 1'b0;
            start_ready <= 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: WIDTH=8 and WIDTH=2 instances, queue scoreboard.
module tb_serial_subtractor;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       start_valid, res_ready;
  logic [7:0] a, b;
  logic       start_ready, res_valid, bout, ovf, busy;
  logic [7:0] diff;

  logic       sv2, rr2;
  logic [1:0] a2, b2;
  logic       sr2, rv2, bo2, ov2, busy2;
  logic [1:0] d2;

  typedef struct packed {logic [7:0] d; logic bo; logic ov;} exp_t;
  exp_t sb[$];
  int errors = 0;
  int checks = 0;

  serial_subtractor #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start_valid(start_valid), .start_ready(start_ready),
    .a(a), .b(b), .res_valid(res_valid), .res_ready(res_ready),
    .diff(diff), .bout(bout), .ovf(ovf), .busy(busy)
  );

  serial_subtractor #(.WIDTH(2)) dut2 (
    .clk(clk), .rst(rst), .start_valid(sv2), .start_ready(sr2),
    .a(a2), .b(b2), .res_valid(rv2), .res_ready(rr2),
    .diff(d2), .bout(bo2), .ovf(ov2), .busy(busy2)
  );

  function automatic exp_t model8(input logic [7:0] x, input logic [7:0] y);
    exp_t e;
    e.d  = x - y;
    e.bo = (x < y);
    e.ov = (x[7] != y[7]) && (e.d[7] != x[7]);
    return e;
  endfunction

  task automatic test_reset();
    rst = 1'b1; start_valid = 1'b0; res_ready = 1'b0; a = '0; b = '0;
    sv2 = 1'b0; rr2 = 1'b0; a2 = '0; b2 = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    checks++;
    if ({start_ready, res_valid, busy} !== 3'b100) begin
      errors++; $display("FAIL reset_ctrl got ready/valid/busy=%b exp=100", {start_ready, res_valid, busy});
    end
    checks++;
    if ({diff, bout, ovf} !== 10'h000) begin
      errors++; $display("FAIL reset_data got diff=%h bout=%b ovf=%b exp 00/0/0", diff, bout, ovf);
    end
    checks++;
    if ({sr2, rv2, busy2, d2, bo2, ov2} !== 7'b1000000) begin
      errors++; $display("FAIL reset_w2 got %b exp 1000000", {sr2, rv2, busy2, d2, bo2, ov2});
    end
  endtask

  task automatic test_basic();
    logic [7:0] ta [0:3];
    logic [7:0] tb_ [0:3];
    logic [7:0] td [0:3];
    logic       tbo [0:3];
    logic       tov [0:3];
    exp_t e;
    int lat;
    ta  = '{8'h5A, 8'h10, 8'h80, 8'h00};
    tb_ = '{8'h23, 8'h20, 8'h01, 8'h00};
    td  = '{8'h37, 8'hF0, 8'h7F, 8'h00};
    tbo = '{1'b0, 1'b1, 1'b0, 1'b0};
    tov = '{1'b0, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      a = ta[i]; b = tb_[i]; start_valid = 1'b1; res_ready = 1'b1;
      sb.push_back('{d: td[i], bo: tbo[i], ov: tov[i]});
      checks++;
      if (start_ready !== 1'b1) begin errors++; $display("FAIL basic_ready[%0d] got=%b exp=1", i, start_ready); end
      @(posedge clk);
      #1 start_valid = 1'b0; a = ~a; b = ~b;
      lat = 0;
      while (res_valid !== 1'b1 && lat < 20) begin
        @(posedge clk); #1 lat++;
        a = 8'($urandom); b = 8'($urandom);
      end
      checks++;
      if (lat != 8) begin errors++; $display("FAIL basic_latency[%0d] got=%0d exp=8", i, lat); end
      e = sb.pop_front();
      checks++;
      if ({diff, bout, ovf} !== e) begin
        errors++; $display("FAIL basic_result[%0d] got diff=%h bout=%b ovf=%b exp %h/%b/%b", i, diff, bout, ovf, e.d, e.bo, e.ov);
      end
      @(posedge clk); #1;
      checks++;
      if ({start_ready, res_valid, diff} !== {1'b1, 1'b0, e.d}) begin
        errors++; $display("FAIL basic_after_hs[%0d] got ready=%b valid=%b diff=%h exp 1/0/%h", i, start_ready, res_valid, diff, e.d);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] oa [0:2];
    logic [7:0] ob [0:2];
    exp_t e;
    int lat, w;
    oa = '{8'h7F, 8'hAB, 8'h01};
    ob = '{8'h80, 8'hAB, 8'hFF};
    @(negedge clk);
    start_valid = 1'b1; res_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a = oa[i]; b = ob[i];
      w = 0;
      while (start_ready !== 1'b1 && w < 20) begin @(posedge clk); #1 w++; end
      checks++;
      if (w != 0) begin errors++; $display("FAIL b2b_ready_wait[%0d] got=%0d exp=0", i, w); end
      sb.push_back(model8(oa[i], ob[i]));
      @(posedge clk);
      #1 a = 8'($urandom); b = 8'($urandom);
      lat = 0;
      while (res_valid !== 1'b1 && lat < 20) begin
        @(posedge clk); #1 lat++;
        a = 8'($urandom); b = 8'($urandom);
      end
      checks++;
      if (lat != 8) begin errors++; $display("FAIL b2b_latency[%0d] got=%0d exp=8", i, lat); end
      e = sb.pop_front();
      checks++;
      if ({diff, bout, ovf} !== e) begin
        errors++; $display("FAIL b2b_result[%0d] got diff=%h bout=%b ovf=%b exp %h/%b/%b", i, diff, bout, ovf, e.d, e.bo, e.ov);
      end
      @(posedge clk); #1;
    end
    start_valid = 1'b0;
  endtask

  task automatic test_stall();
    exp_t e;
    int lat;
    @(negedge clk);
    a = 8'hC3; b = 8'h3C; start_valid = 1'b1; res_ready = 1'b0;
    sb.push_back(model8(8'hC3, 8'h3C));
    @(posedge clk);
    #1 start_valid = 1'b0;
    lat = 0;
    while (res_valid !== 1'b1 && lat < 20) begin @(posedge clk); #1 lat++; end
    checks++;
    if (lat != 8) begin errors++; $display("FAIL stall_latency got=%0d exp=8", lat); end
    e = sb.pop_front();
    for (int k = 0; k < 5; k++) begin
      if (k == 2) begin start_valid = 1'b1; a = 8'h11; b = 8'h22; end
      else start_valid = 1'b0;
      @(posedge clk); #1;
      checks++;
      if ({res_valid, start_ready, diff, bout, ovf} !== {1'b1, 1'b0, e}) begin
        errors++; $display("FAIL stall_hold[%0d] got valid=%b ready=%b diff=%h bout=%b ovf=%b exp 1/0/%h/%b/%b",
                           k, res_valid, start_ready, diff, bout, ovf, e.d, e.bo, e.ov);
      end
    end
    start_valid = 1'b0; res_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({res_valid, start_ready, diff} !== {1'b0, 1'b1, e.d}) begin
      errors++; $display("FAIL stall_release got valid=%b ready=%b diff=%h exp 0/1/%h", res_valid, start_ready, diff, e.d);
    end
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL stall_no_queue got busy=%b exp=0", busy); end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    int lat, seen;
    @(negedge clk);
    a = 8'hFF; b = 8'h01; start_valid = 1'b1; res_ready = 1'b1;
    @(posedge clk);
    #1 start_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    checks++;
    if ({start_ready, res_valid, busy, diff, bout, ovf} !== {3'b100, 10'h000}) begin
      errors++; $display("FAIL rstmid_outputs got ready=%b valid=%b busy=%b diff=%h bout=%b ovf=%b exp 1/0/0/00/0/0",
                         start_ready, res_valid, busy, diff, bout, ovf);
    end
    seen = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      if (res_valid === 1'b1) seen++;
    end
    checks++;
    if (seen != 0) begin errors++; $display("FAIL rstmid_no_result got %0d valid cycles exp=0", seen); end
    @(negedge clk);
    a = 8'h03; b = 8'h05; start_valid = 1'b1;
    sb.push_back('{d: 8'hFE, bo: 1'b1, ov: 1'b0});
    @(posedge clk);
    #1 start_valid = 1'b0;
    lat = 0;
    while (res_valid !== 1'b1 && lat < 20) begin @(posedge clk); #1 lat++; end
    checks++;
    if (lat != 8) begin errors++; $display("FAIL rstmid_latency got=%0d exp=8", lat); end
    e = sb.pop_front();
    checks++;
    if ({diff, bout, ovf} !== e) begin
      errors++; $display("FAIL rstmid_result got diff=%h bout=%b ovf=%b exp %h/%b/%b", diff, bout, ovf, e.d, e.bo, e.ov);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_width2();
    int lat;
    @(negedge clk);
    a2 = 2'b01; b2 = 2'b10; sv2 = 1'b1; rr2 = 1'b1;
    @(posedge clk);
    #1 sv2 = 1'b0; a2 = 2'b11; b2 = 2'b00;
    lat = 0;
    while (rv2 !== 1'b1 && lat < 10) begin @(posedge clk); #1 lat++; end
    checks++;
    if (lat != 2) begin errors++; $display("FAIL w2_latency got=%0d exp=2", lat); end
    // 1 - (-2) = 3 does not fit in a 2-bit signed result, so ovf is set.
    checks++;
    if ({d2, bo2, ov2} !== 4'b1111) begin
      errors++; $display("FAIL w2_result got diff=%b bout=%b ovf=%b exp 11/1/1", d2, bo2, ov2);
    end
    @(posedge clk); #1;
    checks++;
    if ({rv2, sr2} !== 2'b01) begin errors++; $display("FAIL w2_after_hs got valid=%b ready=%b exp 0/1", rv2, sr2); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_stall();
    test_reset_mid();
    test_width2();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
